tx_arbiter: RTL and testbench

- Shares one multi-frame UART transmitter (DATA_SIZE bits per transfer, sent as FRAMES frames) between NUM_REQ requesters.
- Round-robin arbitration selects one requester. The block captures that requester's word, launches it into the transmitter with a one-cycle strobe, and tracks the transmitter's busy flag until the transfer completes.
- Sits between the accelerator's result/debug sources and the UART TX path.

---
 rtl/tx_arbiter_pkg.sv | 6 +
 rtl/tx_arbiter_if.sv | 23 ++
 rtl/tx_arbiter_rr_pick.sv | 22 ++
 rtl/tx_arbiter.sv | 84 ++++++++
 tb/tb_tx_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/tx_arbiter_pkg.sv
// tx_arb_pkg: shared types and constants for the UART TX arbiter
package tx_arb_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_e;
  localparam int START_TIMEOUT = 4;
  localparam int TMO_W = $clog2(START_TIMEOUT + 1);
endpackage

// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if: requester bundle plus transmitter handshake around the arbiter
interface tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_SIZE = 16,
  localparam int ID_W = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req_valid_in;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data_in;
  logic [NUM_REQ-1:0] req_accept_out;
  logic trans_busy_in;
  logic trans_new_data_out;
  logic [DATA_SIZE-1:0] trans_data_out;
  logic [ID_W-1:0] grant_id_out;
  logic busy_out;
  modport master (
    output req_valid_in, req_data_in, trans_busy_in,
    input req_accept_out, trans_new_data_out, trans_data_out, grant_id_out, busy_out
  );
  modport slave (
    input req_valid_in, req_data_in, trans_busy_in,
    output req_accept_out, trans_new_data_out, trans_data_out, grant_id_out, busy_out
  );
endinterface

// File: rtl/tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit at or above ptr with wrap
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  logic [W-1:0] j;
  assign any_o = |req_i;
  // scan from farthest to nearest so the candidate closest to ptr wins
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr_i) + k) % N);
      if (req_i[j]) idx_o = j;
    end
  end
endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin sharing of one UART transmitter between requesters
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_SIZE = 16,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input logic clk_in,
  input logic rst_in,
  tx_arbiter_if.slave bus
);
  state_e state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, win;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [NUM_REQ-1:0] accept_q, accept_d;
  logic strobe_q, strobe_d, busy_q, busy_d, launch_err_q, launch_err_d, any;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i(bus.req_valid_in),
    .ptr_i(rr_ptr_q),
    .idx_o(win),
    .any_o(any)
  );
  assign bus.req_accept_out = accept_q;
  assign bus.trans_new_data_out = strobe_q;
  assign bus.trans_data_out = data_q;
  assign bus.grant_id_out = grant_q;
  assign bus.busy_out = busy_q;
  // next-state, capture and registered-output decode
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d = grant_q;
    data_d = data_q;
    tmo_d = tmo_q;
    launch_err_d = launch_err_q;
    case (state_q)
      IDLE: if (any && !bus.trans_busy_in) begin
        state_d = LAUNCH;
        grant_d = win;
        data_d = bus.req_data_in[int'(win)*DATA_SIZE +: DATA_SIZE];
        rr_ptr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
      LAUNCH: begin
        state_d = WAIT_START;
        tmo_d = '0;
      end
      WAIT_START: if (bus.trans_busy_in) state_d = WAIT_DONE;
        else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
          state_d = IDLE;
          launch_err_d = 1'b1;
        end else tmo_d = tmo_q + 1'b1;
      WAIT_DONE: if (!bus.trans_busy_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    strobe_d = state_d == LAUNCH;
    accept_d = strobe_d ? NUM_REQ'(1) << grant_d : '0;
    busy_d = state_d != IDLE;
  end
  // state and output registers, cleared immediately by reset
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_q <= '0;
      data_q <= '0;
      tmo_q <= '0;
      launch_err_q <= 1'b0;
      accept_q <= '0;
      strobe_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q <= grant_d;
      data_q <= data_d;
      tmo_q <= tmo_d;
      launch_err_q <= launch_err_d;
      accept_q <= accept_d;
      strobe_q <= strobe_d;
      busy_q <= busy_d;
    end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed tests with a transaction-level round-robin model
module tb_tx_arbiter;
  import tx_arb_pkg::*;
  localparam int N = 4;
  localparam int DW = 16;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  tx_arbiter_if #(.NUM_REQ(N), .DATA_SIZE(DW)) bus ();
  tx_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  logic tx_busy = 0, ext_busy = 0, tx_dead = 0;
  int tx_len = 40;
  assign bus.trans_busy_in = tx_busy | ext_busy;
  logic [DW-1:0] words [N];
  int passed = 0, total = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic set_req(input logic [N-1:0] v);
    bus.req_valid_in = v;
    for (int i = 0; i < N; i++) bus.req_data_in[i*DW +: DW] = words[i];
  endtask
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction
  // transmitter model: busy from the edge after the strobe for tx_len cycles
  initial forever begin
    @(negedge clk);
    if (bus.trans_new_data_out === 1'b1 && !tx_dead && !rst) begin
      @(posedge clk);
      #1 tx_busy = 1;
      repeat (tx_len) @(posedge clk);
      #1 tx_busy = 0;
    end
  end
  // reference model: a launch follows every idle cycle with a request and quiet transmitter
  int m_ptr = 0, cyc = 0, w;
  int grants[$], stimes[$];
  logic [N-1:0] p_valid = '0;
  logic [N*DW-1:0] p_data = '0;
  logic p_busyin = 0, p_busyout = 0, p_rst = 1, exp_s;
  always @(negedge clk) begin
    cyc++;
    if (rst || p_rst) m_ptr = 0;
    else begin
      exp_s = !p_busyout && (p_valid != '0) && !p_busyin;
      check("m_strobe", 32'(bus.trans_new_data_out), 32'(exp_s));
      if (!p_busyout) check("m_busy_out", 32'(bus.busy_out), 32'(exp_s));
      if (exp_s) begin
        w = pick(p_valid, m_ptr);
        check("m_grant", 32'(bus.grant_id_out), w);
        check("m_accept", 32'(bus.req_accept_out), 32'(1) << w);
        check("m_data", 32'(bus.trans_data_out), 32'(p_data[w*DW +: DW]));
        m_ptr = (w + 1) % N;
        grants.push_back(w);
        stimes.push_back(cyc);
      end else check("m_accept_zero", 32'(bus.req_accept_out), 0);
    end
    p_valid = bus.req_valid_in;
    p_data = bus.req_data_in;
    p_busyin = bus.trans_busy_in;
    p_busyout = bus.busy_out;
    p_rst = rst;
  end
  task automatic wait_strobe(input int max, output int c);
    c = -1;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (bus.trans_new_data_out === 1'b1) begin
        c = k;
        break;
      end
    end
  endtask
  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!bus.busy_out && !bus.trans_busy_in) break;
    end
    check({name, "_idle_timeout"}, 32'(k < 300), 1);
  endtask
  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c, k;
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'hBEEF;
    words[3] = 16'h4444;
    set_req('0);
    @(negedge clk);
    check("rst_strobe", 32'(bus.trans_new_data_out), 0);
    check("rst_accept", 32'(bus.req_accept_out), 0);
    check("rst_data", 32'(bus.trans_data_out), 0);
    check("rst_grant", 32'(bus.grant_id_out), 0);
    check("rst_busy", 32'(bus.busy_out), 0);
    @(posedge clk);
    #1 rst = 0;
    // single request from requester 2
    @(posedge clk);
    #1 set_req(4'b0100);
    wait_strobe(5, c);
    check("t1_latency", c, 1);
    check("t1_accept", 32'(bus.req_accept_out), 32'h4);
    check("t1_data", 32'(bus.trans_data_out), 32'hBEEF);
    check("t1_grant", 32'(bus.grant_id_out), 2);
    @(posedge clk);
    #1 set_req('0);
    @(negedge clk);
    check("t1_busy_rise", 32'(bus.trans_busy_in), 1);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.trans_busy_in) break;
    end
    check("t1_busy_fall_seen", 32'(k < 100), 1);
    check("t1_busy_out_hold", 32'(bus.busy_out), 1);
    @(negedge clk);
    check("t1_busy_out_low", 32'(bus.busy_out), 0);
    // all four continuously valid from rr_ptr=0
    tx_len = 5;
    pulse_reset();
    wait_idle("t2");
    grants.delete();
    stimes.delete();
    @(posedge clk);
    #1 set_req(4'b1111);
    for (k = 0; k < 200 && grants.size() < 5; k++) @(negedge clk);
    @(posedge clk);
    #1 set_req('0);
    check("t2_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) check("t2_order", grants[i], i % 4);
    if (stimes.size() >= 2) check("t2_period", stimes[1] - stimes[0], tx_len + 3);
    // wrap: grant 2 leaves rr_ptr at 3, then 0011 gives 0 then 1
    wait_idle("t3a");
    @(posedge clk);
    #1 set_req(4'b0100);
    wait_strobe(5, c);
    check("t3_pre_grant", 32'(bus.grant_id_out), 2);
    @(posedge clk);
    #1 set_req('0);
    wait_idle("t3b");
    grants.delete();
    @(posedge clk);
    #1 set_req(4'b0011);
    for (k = 0; k < 100 && grants.size() < 2; k++) @(negedge clk);
    @(posedge clk);
    #1 set_req('0);
    check("t3_count", grants.size(), 2);
    if (grants.size() >= 2) begin
      check("t3_first", grants[0], 0);
      check("t3_second", grants[1], 1);
    end
    // stale external busy holds off the grant
    wait_idle("t4");
    @(posedge clk);
    #1 begin ext_busy = 1; set_req(4'b0001); end
    repeat (4) begin
      @(negedge clk);
      check("t4_no_strobe", 32'(bus.trans_new_data_out), 0);
      check("t4_no_accept", 32'(bus.req_accept_out), 0);
    end
    @(posedge clk);
    #1 ext_busy = 0;
    wait_strobe(5, c);
    check("t4_latency", c, 1);
    check("t4_accept", 32'(bus.req_accept_out), 32'h1);
    @(posedge clk);
    #1 set_req('0);
    // transmitter never starts: timeout after START_TIMEOUT cycles in WAIT_START
    wait_idle("t5");
    check("t5_err_pre", 32'(dut.launch_err_q), 0);
    tx_dead = 1;
    @(posedge clk);
    #1 set_req(4'b0010);
    wait_strobe(5, c);
    check("t5_latency", c, 1);
    check("t5_grant", 32'(bus.grant_id_out), 1);
    @(posedge clk);
    #1 set_req('0);
    @(negedge clk);
    for (int i = 1; i <= START_TIMEOUT; i++) begin
      check("t5_wait_busy", 32'(bus.busy_out), 1);
      check("t5_no_reaccept", 32'(bus.req_accept_out), 0);
      @(negedge clk);
    end
    check("t5_back_idle", 32'(bus.busy_out), 0);
    check("t5_launch_err", 32'(dut.launch_err_q), 1);
    tx_dead = 0;
    // asynchronous reset in WAIT_DONE, then grant 3 from rr_ptr=0
    tx_len = 20;
    @(posedge clk);
    #1 set_req(4'b0100);
    wait_strobe(5, c);
    check("t6_grant_pre", 32'(bus.grant_id_out), 2);
    @(posedge clk);
    #1 set_req('0);
    repeat (4) @(negedge clk);
    check("t6_in_transfer", 32'(bus.busy_out), 1);
    #2 rst = 1;
    #1;
    check("t6_rst_busy", 32'(bus.busy_out), 0);
    check("t6_rst_data", 32'(bus.trans_data_out), 0);
    check("t6_rst_grant", 32'(bus.grant_id_out), 0);
    check("t6_rst_strobe", 32'(bus.trans_new_data_out), 0);
    check("t6_rst_accept", 32'(bus.req_accept_out), 0);
    check("t6_rst_err", 32'(dut.launch_err_q), 0);
    for (k = 0; k < 100 && tx_busy; k++) @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1 set_req(4'b1000);
    wait_strobe(5, c);
    check("t6_latency", c, 1);
    check("t6_grant", 32'(bus.grant_id_out), 3);
    check("t6_accept", 32'(bus.req_accept_out), 32'h8);
    check("t6_data", 32'(bus.trans_data_out), 32'h4444);
    @(posedge clk);
    #1 set_req('0);
    wait_idle("t6_end");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
